flag_unit: RTL and testbench
============================

FLAG_UNIT -- requirements
Module: flag_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 SrcA  input  32  ALU operand A.
REQ-005 SrcB  input  32  ALU operand B.
REQ-006 ALUControl  input  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 FlagW  input  2  bit1 = write N,Z group; bit0 = write C,V group.
REQ-008 CondEx  input  1  condition-pass for the current instruction; gates all flag writes.
REQ-009 Stall  input  1  holds the flag register; no normal write.
REQ-010 Flush  input  1  current instruction squashed; no normal write.
REQ-011 SaveReq  input  1  copy Flags into shadow register.
REQ-012 RestoreReq  input  1  copy shadow register into Flags.
REQ-013 RawFlags  output  4  combinational {N,Z,C,V} of the current operation.
REQ-014 ALUFlags  output  4  registered architectural {N,Z,C,V}; drives condition evaluation.
REQ-015 SavedFlags  output  4  registered shadow {N,Z,C,V}.
REQ-016 FlagsUpd  output  1  registered pulse: high the cycle after any change-eligible write to ALUFlags.

Function
REQ-017 Internal result SHALL be: ADD A+B; SUB A+~B+1; AND A&B; ORR A|B; all 32-bit, carry-out from a 33-bit sum.
REQ-018 RawFlags.N SHALL equal result[31]; RawFlags.Z SHALL equal (result == 0).
REQ-019 For ADD/SUB, RawFlags.C SHALL be bit 32 of the 33-bit sum (SUB: 1 = no borrow).
REQ-020 For ADD, V SHALL be (A[31]==B[31]) & (result[31]!=A[31]); for SUB, V SHALL be (A[31]!=B[31]) & (result[31]!=A[31]).
REQ-021 For AND/ORR, RawFlags.C and RawFlags.V SHALL be 0.
REQ-022 Normal write enable WE SHALL be CondEx & ~Stall & ~Flush.
REQ-023 When WE & FlagW[1], ALUFlags[3:2] SHALL load RawFlags[3:2] at the next edge; otherwise hold.
REQ-024 When WE & FlagW[0], ALUFlags[1:0] SHALL load RawFlags[1:0] at the next edge; otherwise hold.
REQ-025 RestoreReq SHALL load ALUFlags <= SavedFlags (all 4 bits), overriding any normal write in the same cycle.
REQ-026 SaveReq SHALL load SavedFlags <= ALUFlags (pre-edge value, not the value being written).
REQ-027 SaveReq and RestoreReq together SHALL swap ALUFlags and SavedFlags in one cycle.
REQ-028 SaveReq and RestoreReq SHALL act regardless of Stall, Flush and CondEx.
REQ-029 FlagsUpd SHALL be 1 in the cycle after an edge where RestoreReq, or WE with FlagW != 00, was asserted; else 0.
REQ-030 CondEx=0 with FlagW!=00 SHALL leave ALUFlags unchanged and FlagsUpd low.
REQ-031 RawFlags SHALL depend only on SrcA, SrcB, ALUControl (no state).
REQ-032 Latency: flag write visible on ALUFlags exactly one cycle after the enabling edge.

Reset
REQ-033 reset SHALL have priority over all other inputs, including SaveReq/RestoreReq.
REQ-034 On reset ALUFlags=0000, SavedFlags=0000, FlagsUpd=0.
REQ-035 Reset asserted mid-operation SHALL discard any write, save or restore in that cycle.

Verification
REQ-036 SUB A=5,B=5,FlagW=11,CondEx=1 -> next cycle ALUFlags=0110 (Z=1,C=1), FlagsUpd=1.
REQ-037 ADD A=0x7FFFFFFF,B=1,FlagW=11 -> ALUFlags=1001 (N=1,V=1); then SUB A=0,B=1 -> 1000.
REQ-038 From ALUFlags=0110, AND A=0x80000000,B=0xFFFFFFFF,FlagW=10 -> ALUFlags=1010 (C,V held).
REQ-039 FlagW=11 with CondEx=0, or Stall=1, or Flush=1 -> ALUFlags unchanged, FlagsUpd=0.
REQ-040 ALUFlags=0110, SaveReq=1 plus SUB 5-5 write -> SavedFlags=0110; later RestoreReq with concurrent write -> ALUFlags=SavedFlags; Save+Restore together with ALUFlags=1001,Saved=0110 -> swapped.
REQ-041 reset=1 concurrent with RestoreReq and FlagW=11 -> ALUFlags=0000, SavedFlags=0000, FlagsUpd=0.

Source files
------------

// File: rtl/flag_unit.sv
// Condition-flag generation, architectural flag register and shadow copy.
// RawFlags is combinational; ALUFlags/SavedFlags update on the next edge.
module flag_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [1:0]  ALUControl,
  input  logic [1:0]  FlagW,
  input  logic        CondEx,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        SaveReq,
  input  logic        RestoreReq,
  output logic [3:0]  RawFlags,
  output logic [3:0]  ALUFlags,
  output logic [3:0]  SavedFlags,
  output logic        FlagsUpd
);

  logic [31:0] bop;
  logic [32:0] sum;
  logic [31:0] result;
  logic        n, z, c, v;
  logic        we;
  logic [3:0]  next_flags;

  // SUB reuses the adder as A + ~B + 1
  always_comb begin
    bop = ALUControl[0] ? ~SrcB : SrcB;
    sum = {1'b0, SrcA} + {1'b0, bop} + {32'd0, ALUControl[0]};
  end

  always_comb begin
    result = 32'd0;
    c      = 1'b0;
    v      = 1'b0;
    unique case (ALUControl)
      2'b00: begin
        result = sum[31:0];
        c      = sum[32];
        v      = (SrcA[31] == SrcB[31]) & (result[31] != SrcA[31]);
      end
      2'b01: begin
        result = sum[31:0];
        c      = sum[32];
        v      = (SrcA[31] != SrcB[31]) & (result[31] != SrcA[31]);
      end
      2'b10: result = SrcA & SrcB;
      2'b11: result = SrcA | SrcB;
      default: result = 32'd0;
    endcase
    n = result[31];
    z = (result == 32'd0);
  end

  assign RawFlags = {n, z, c, v};
  assign we       = CondEx & ~Stall & ~Flush;

  always_comb begin
    next_flags = ALUFlags;
    if (we & FlagW[1]) next_flags[3:2] = RawFlags[3:2];
    if (we & FlagW[0]) next_flags[1:0] = RawFlags[1:0];
    if (RestoreReq)    next_flags      = SavedFlags;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ALUFlags   <= 4'b0000;
      SavedFlags <= 4'b0000;
      FlagsUpd   <= 1'b0;
    end else begin
      ALUFlags <= next_flags;
      if (SaveReq) SavedFlags <= ALUFlags;
      FlagsUpd <= RestoreReq | (we & (FlagW != 2'b00));
    end
  end

endmodule

// File: tb/tb_flag_unit.sv
// Directed table-driven bench for flag_unit.
// Each row is one cycle; expected values are hand-computed {N,Z,C,V}.
module tb_flag_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] SrcA, SrcB;
  logic [1:0]  ALUControl, FlagW;
  logic        CondEx, Stall, Flush, SaveReq, RestoreReq;
  logic [3:0]  RawFlags, ALUFlags, SavedFlags;
  logic        FlagsUpd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flag_unit dut (
    .clk(clk), .reset(reset),
    .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .FlagW(FlagW),
    .CondEx(CondEx), .Stall(Stall), .Flush(Flush),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq),
    .RawFlags(RawFlags), .ALUFlags(ALUFlags),
    .SavedFlags(SavedFlags), .FlagsUpd(FlagsUpd)
  );

  typedef struct {
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  ctl;
    logic [1:0]  fw;
    logic        ce;
    logic        st;
    logic        fl;
    logic        sv;
    logic        rs;
    logic [3:0]  raw;
    logic [3:0]  flags;
    logic [3:0]  saved;
    logic        upd;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  task automatic chk4(input string nm, input logic [3:0] act,
                      input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    reset      = t.rst;
    SrcA       = t.a;
    SrcB       = t.b;
    ALUControl = t.ctl;
    FlagW      = t.fw;
    CondEx     = t.ce;
    Stall      = t.st;
    Flush      = t.fl;
    SaveReq    = t.sv;
    RestoreReq = t.rs;
  endtask

  logic [3:0] prev_flags;

  initial begin
    //          rst a             b             ctl   fw    ce st fl sv rs raw      flags    saved    upd
    tv[0]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,0,0,0,0,4'b0110,4'b0110,4'b0000,1};
    tv[1]  = '{0, 32'h7FFFFFFF, 32'd1,        2'b00,2'b11,1,0,0,0,0,4'b1001,4'b1001,4'b0000,1};
    tv[2]  = '{0, 32'd0,        32'd1,        2'b01,2'b11,1,0,0,0,0,4'b1000,4'b1000,4'b0000,1};
    tv[3]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,0,0,0,0,4'b0110,4'b0110,4'b0000,1};
    tv[4]  = '{0, 32'h80000000, 32'hFFFFFFFF, 2'b10,2'b10,1,0,0,0,0,4'b1000,4'b1010,4'b0000,1};
    tv[5]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,0,0,0,0,0,4'b0110,4'b1010,4'b0000,0};
    tv[6]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,1,0,0,0,4'b0110,4'b1010,4'b0000,0};
    tv[7]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,0,1,0,0,4'b0110,4'b1010,4'b0000,0};
    tv[8]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,0,0,0,0,4'b0110,4'b0110,4'b0000,1};
    tv[9]  = '{0, 32'd5,        32'd5,        2'b01,2'b11,1,0,0,1,0,4'b0110,4'b0110,4'b0110,1};
    tv[10] = '{0, 32'h7FFFFFFF, 32'd1,        2'b00,2'b11,1,0,0,0,0,4'b1001,4'b1001,4'b0110,1};
    tv[11] = '{0, 32'd0,        32'd0,        2'b11,2'b00,1,0,0,0,0,4'b0100,4'b1001,4'b0110,0};
    tv[12] = '{0, 32'd0,        32'd0,        2'b11,2'b00,1,0,0,1,1,4'b0100,4'b0110,4'b1001,1};
    tv[13] = '{0, 32'd0,        32'd0,        2'b11,2'b11,1,0,0,0,1,4'b0100,4'b1001,4'b1001,1};
    tv[14] = '{0, 32'd0,        32'd0,        2'b11,2'b11,1,0,0,0,0,4'b0100,4'b0100,4'b1001,1};
    tv[15] = '{0, 32'd0,        32'd0,        2'b11,2'b00,0,1,1,0,1,4'b0100,4'b1001,4'b1001,1};
    tv[16] = '{0, 32'hFFFFFFFF, 32'd0,        2'b11,2'b01,1,0,0,0,0,4'b1000,4'b1000,4'b1001,1};
    tv[17] = '{0, 32'hFFFFFFFF, 32'd1,        2'b00,2'b01,1,0,0,0,0,4'b0110,4'b1010,4'b1001,1};
    tv[18] = '{0, 32'h80000000, 32'd1,        2'b01,2'b11,1,0,0,0,0,4'b0011,4'b0011,4'b1001,1};
    tv[19] = '{1, 32'd5,        32'd5,        2'b01,2'b11,1,0,0,1,1,4'b0110,4'b0000,4'b0000,0};
    tv[20] = '{0, 32'd5,        32'd5,        2'b01,2'b00,0,0,0,0,1,4'b0110,4'b0000,4'b0000,1};

    drive('{1,0,0,2'b00,2'b00,0,0,0,0,0,4'b0,4'b0,4'b0,0});
    repeat (2) @(posedge clk);
    #1;
    chk4("reset_flags", ALUFlags, 4'b0000);
    chk4("reset_saved", SavedFlags, 4'b0000);
    chk1("reset_upd", FlagsUpd, 1'b0);
    prev_flags = 4'b0000;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk4($sformatf("raw[%0d]", i), RawFlags, tv[i].raw);
      chk4($sformatf("preedge[%0d]", i), ALUFlags, prev_flags);
      @(posedge clk);
      #1;
      chk4($sformatf("flags[%0d]", i), ALUFlags, tv[i].flags);
      chk4($sformatf("saved[%0d]", i), SavedFlags, tv[i].saved);
      chk1($sformatf("upd[%0d]", i), FlagsUpd, tv[i].upd);
      prev_flags = tv[i].flags;
    end

    // Hold a write under Stall for several cycles, then release it
    @(negedge clk);
    drive('{0,32'h7FFFFFFF,32'd1,2'b00,2'b11,1,1,0,0,0,4'b1001,4'b0,4'b0,0});
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk4($sformatf("stall_hold[%0d]", k), ALUFlags, 4'b0000);
      chk1($sformatf("stall_upd[%0d]", k), FlagsUpd, 1'b0);
    end
    @(negedge clk);
    Stall = 1'b0;
    @(posedge clk);
    #1;
    chk4("stall_release", ALUFlags, 4'b1001);
    chk1("stall_release_upd", FlagsUpd, 1'b1);
    @(negedge clk);
    FlagW = 2'b00;
    @(posedge clk);
    #1;
    chk1("upd_pulse_end", FlagsUpd, 1'b0);
    chk4("idle_hold", ALUFlags, 4'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
